bf16_accelerator_top: RTL and testbench

Single-cycle-latency BF16 arithmetic/conversion unit, used as the floating-point accelerator tile beside the integer datapath. It accepts one operation per clock when enabled: FP32↔BF16 conversion, BF16 multiply, and BF16 min/max. Results and exception flags are registered, and `valid` marks each completed operation.

---
 rtl/bf16_accelerator_top.sv | 198 +++++++++++++++++++
 tb/tb_bf16_accelerator_top.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bf16_accelerator_top.sv
// rtl/bf16_accelerator_top.sv - single-cycle BF16 arithmetic/conversion tile
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   enable     sample operands/operation at this edge
//   operand_a  FP32 source (op 0001) or BF16 source in [15:0]
//   operand_b  BF16 second source in [15:0]
//   operand_c  reserved, ignored
//   operation  opcode: 0000 bf16->fp32, 0001 fp32->bf16, 0010 mul, 0011 min, 0100 max
//   result     registered result (BF16 results zero-extended)
//   fpcsr      registered flags {NV, OF, UF, NX}
//   valid      high the cycle after an enabled sample
module bf16_accelerator_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] operand_c,
    input  logic [3:0]  operation,
    output logic [31:0] result,
    output logic [3:0]  fpcsr,
    output logic        valid
);
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    logic [31:0] result_q, result_d;
    logic [3:0]  fpcsr_q, fpcsr_d;
    logic        valid_q, valid_d;

    logic unused_bits;
    assign unused_bits = ^{operand_c, operand_b[31:16]};

    // BF16 operand fields
    logic [15:0] a16, b16;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [6:0]  ma, mb;
    logic        nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

    assign a16    = operand_a[15:0];
    assign b16    = operand_b[15:0];
    assign sa     = a16[15];
    assign sb     = b16[15];
    assign ea     = a16[14:7];
    assign eb     = b16[14:7];
    assign ma     = a16[6:0];
    assign mb     = b16[6:0];
    assign nan_a  = (ea == 8'hFF) && (ma != 7'd0);
    assign nan_b  = (eb == 8'hFF) && (mb != 7'd0);
    assign snan_a = nan_a && !ma[6];
    assign snan_b = nan_b && !mb[6];
    assign inf_a  = (ea == 8'hFF) && (ma == 7'd0);
    assign inf_b  = (eb == 8'hFF) && (mb == 7'd0);
    // Subnormals are flushed, so exponent zero alone means zero for the multiplier
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);

    // FP32 -> BF16 rounding
    logic        f_nan, f_snan, f_inf, f_sub, f_zero, f_rnd, f_nx;
    logic [14:0] f_mag;

    assign f_nan  = (operand_a[30:23] == 8'hFF) && (operand_a[22:0] != 23'd0);
    assign f_snan = f_nan && !operand_a[22];
    assign f_inf  = (operand_a[30:23] == 8'hFF) && (operand_a[22:0] == 23'd0);
    assign f_sub  = (operand_a[30:23] == 8'h00) && (operand_a[22:0] != 23'd0);
    assign f_zero = (operand_a[30:0] == 31'd0);
    assign f_rnd  = operand_a[15] && ((operand_a[14:0] != 15'd0) || operand_a[16]);
    assign f_nx   = (operand_a[15:0] != 16'd0);
    // Finite exponent is at most 0xFE, so the carry can reach 0xFF but never beyond
    assign f_mag  = operand_a[30:16] + {14'd0, f_rnd};

    // BF16 multiply datapath
    logic [15:0] prod;
    logic        norm, guard, sticky, round_up, mul_sign, mul_nx;
    logic [6:0]  mant_n;
    logic [7:0]  mant_r;
    logic [10:0] exp_b;
    logic [10:0] exp_u;

    assign prod     = {8'd0, 1'b1, ma} * {8'd0, 1'b1, mb};
    assign norm     = prod[15];
    assign mant_n   = norm ? prod[14:8] : prod[13:7];
    assign guard    = norm ? prod[7] : prod[6];
    assign sticky   = norm ? (prod[6:0] != 7'd0) : (prod[5:0] != 6'd0);
    assign round_up = guard && (sticky || mant_n[0]);
    assign mant_r   = {1'b0, mant_n} + {7'd0, round_up};
    assign mul_nx   = guard || sticky;
    assign mul_sign = sa ^ sb;
    // Exponent kept biased twice (ea+eb) to stay unsigned; true exponent = exp_b - 127
    assign exp_b    = {3'd0, ea} + {3'd0, eb} + {10'd0, norm} + {10'd0, mant_r[7]};
    assign exp_u    = exp_b - 11'd127;

    // Total order for non-NaN BF16 values, with -0 below +0
    logic [15:0] key_a, key_b;
    logic        a_lt_b;

    assign key_a  = sa ? ~a16 : (a16 | 16'h8000);
    assign key_b  = sb ? ~b16 : (b16 | 16'h8000);
    assign a_lt_b = key_a < key_b;

    always_comb begin
        result_d = result_q;
        fpcsr_d  = fpcsr_q;
        valid_d  = 1'b0;
        if (enable) begin
            valid_d  = 1'b1;
            result_d = 32'd0;
            fpcsr_d  = 4'b0000;
            case (operation)
                4'b0000: begin
                    if (nan_a) begin
                        result_d = FP32_QNAN;
                        fpcsr_d  = {snan_a, 3'b000};
                    end else begin
                        result_d = {a16, 16'h0000};
                    end
                end
                4'b0001: begin
                    if (f_nan) begin
                        result_d = {16'd0, BF16_QNAN};
                        fpcsr_d  = {f_snan, 3'b000};
                    end else if (f_inf || f_zero) begin
                        result_d = {16'd0, operand_a[31:16]};
                    end else if (f_sub) begin
                        result_d = {16'd0, operand_a[31], 15'd0};
                        fpcsr_d  = 4'b0011;
                    end else if (f_mag[14:7] == 8'hFF) begin
                        result_d = {16'd0, operand_a[31], 15'h7F80};
                        fpcsr_d  = 4'b0101;
                    end else begin
                        result_d = {16'd0, operand_a[31], f_mag};
                        fpcsr_d  = {3'b000, f_nx};
                    end
                end
                4'b0010: begin
                    if (nan_a || nan_b) begin
                        result_d = {16'd0, BF16_QNAN};
                        fpcsr_d  = {snan_a || snan_b, 3'b000};
                    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
                        result_d = {16'd0, BF16_QNAN};
                        fpcsr_d  = 4'b1000;
                    end else if (inf_a || inf_b) begin
                        result_d = {16'd0, mul_sign, 15'h7F80};
                    end else if (zero_a || zero_b) begin
                        result_d = {16'd0, mul_sign, 15'd0};
                    end else if (exp_b >= 11'd382) begin
                        result_d = {16'd0, mul_sign, 15'h7F80};
                        fpcsr_d  = 4'b0101;
                    end else if (exp_b <= 11'd127) begin
                        result_d = {16'd0, mul_sign, 15'd0};
                        fpcsr_d  = 4'b0011;
                    end else begin
                        result_d = {16'd0, mul_sign, exp_u[7:0], mant_r[6:0]};
                        fpcsr_d  = {3'b000, mul_nx};
                    end
                end
                4'b0011, 4'b0100: begin
                    fpcsr_d = {snan_a || snan_b, 3'b000};
                    if (nan_a && nan_b) begin
                        result_d = {16'd0, BF16_QNAN};
                    end else if (nan_a) begin
                        result_d = {16'd0, b16};
                    end else if (nan_b) begin
                        result_d = {16'd0, a16};
                    end else if (operation == 4'b0011) begin
                        result_d = {16'd0, a_lt_b ? a16 : b16};
                    end else begin
                        result_d = {16'd0, a_lt_b ? b16 : a16};
                    end
                end
                default: begin
                    result_d = 32'd0;
                    fpcsr_d  = 4'b1000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 32'd0;
            fpcsr_q  <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            fpcsr_q  <= fpcsr_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign fpcsr  = fpcsr_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_bf16_accelerator_top.sv
// tb/tb_bf16_accelerator_top.sv - directed self-checking bench for bf16_accelerator_top
module tb_bf16_accelerator_top;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] operand_c;
    logic [3:0]  operation;
    logic [31:0] result;
    logic [3:0]  fpcsr;
    logic        valid;

    int checks = 0;
    int errors = 0;

    bf16_accelerator_top dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operand_c (operand_c),
        .operation (operation),
        .result    (result),
        .fpcsr     (fpcsr),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags);
        @(negedge clk);
        operation = op;
        operand_a = a;
        operand_b = b;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".fpcsr"}, {28'd0, fpcsr}, {28'd0, exp_flags});
        chk({tag, ".valid"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        operand_c = 32'hA5A5_A5A5;
        operation = 4'b0000;

        #12;
        chk("reset.result", result, 32'd0);
        chk("reset.fpcsr", {28'd0, fpcsr}, 32'd0);
        chk("reset.valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // FP32 -> BF16
        run_op("f2b_pi",      4'b0001, 32'h40490FDB, 32'd0, 32'h0000_4049, 4'b0001);
        run_op("f2b_zero",    4'b0001, 32'h00000000, 32'd0, 32'h0000_0000, 4'b0000);
        run_op("f2b_inf",     4'b0001, 32'h7F800000, 32'd0, 32'h0000_7F80, 4'b0000);
        run_op("f2b_qnan",    4'b0001, 32'hFFC00000, 32'd0, 32'h0000_7FC0, 4'b0000);
        run_op("f2b_ovf",     4'b0001, 32'h7F7FFFFF, 32'd0, 32'h0000_7F80, 4'b0101);
        run_op("f2b_tie",     4'b0001, 32'h3F818000, 32'd0, 32'h0000_3F82, 4'b0001);
        run_op("f2b_snan",    4'b0001, 32'h7F800001, 32'd0, 32'h0000_7FC0, 4'b1000);
        run_op("f2b_sub",     4'b0001, 32'h80000001, 32'd0, 32'h0000_8000, 4'b0011);

        // BF16 -> FP32 (upper operand bits must be ignored)
        run_op("b2f_norm",    4'b0000, 32'hDEAD3C00, 32'd0, 32'h3C00_0000, 4'b0000);
        run_op("b2f_zero",    4'b0000, 32'h00000000, 32'd0, 32'h0000_0000, 4'b0000);
        run_op("b2f_inf",     4'b0000, 32'h00007F80, 32'd0, 32'h7F80_0000, 4'b0000);
        run_op("b2f_qnan",    4'b0000, 32'h00007FC0, 32'd0, 32'h7FC0_0000, 4'b0000);
        run_op("b2f_snan",    4'b0000, 32'h00007F81, 32'd0, 32'h7FC0_0000, 4'b1000);

        // Multiply
        run_op("mul_basic",   4'b0010, 32'h00003FC0, 32'h00004000, 32'h0000_4040, 4'b0000);
        run_op("mul_neg",     4'b0010, 32'h0000BFC0, 32'hFFFF4000, 32'h0000_C040, 4'b0000);
        run_op("mul_infzero", 4'b0010, 32'h00007F80, 32'h00000000, 32'h0000_7FC0, 4'b1000);
        run_op("mul_ovf",     4'b0010, 32'h00007F00, 32'h00007F00, 32'h0000_7F80, 4'b0101);
        run_op("mul_unf",     4'b0010, 32'h00000080, 32'h00000080, 32'h0000_0000, 4'b0011);
        run_op("mul_inexact", 4'b0010, 32'h00003F81, 32'h00003F81, 32'h0000_3F82, 4'b0001);
        run_op("mul_norm",    4'b0010, 32'h00003FFF, 32'h00003FFF, 32'h0000_407E, 4'b0001);
        run_op("mul_negzero", 4'b0010, 32'h00008000, 32'h00003F80, 32'h0000_8000, 4'b0000);

        // Async reset with a nonzero result held
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.result", result, 32'd0);
        chk("midreset.fpcsr", {28'd0, fpcsr}, 32'd0);
        chk("midreset.valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Min / max
        run_op("max_sign",    4'b0100, 32'h0000BF80, 32'h00003F80, 32'h0000_3F80, 4'b0000);
        run_op("min_sign",    4'b0011, 32'h0000BF80, 32'h00003F80, 32'h0000_BF80, 4'b0000);
        run_op("min_zeros",   4'b0011, 32'h00000000, 32'h00008000, 32'h0000_8000, 4'b0000);
        run_op("max_zeros",   4'b0100, 32'h00008000, 32'h00000000, 32'h0000_0000, 4'b0000);
        run_op("max_qnan",    4'b0100, 32'h00007FC0, 32'h00004000, 32'h0000_4000, 4'b0000);
        run_op("min_bothnan", 4'b0011, 32'h00007FC0, 32'h0000FFC0, 32'h0000_7FC0, 4'b0000);
        run_op("max_snan",    4'b0100, 32'h00007F81, 32'h00003F80, 32'h0000_3F80, 4'b1000);

        // Enable low: hold result/flags, valid low
        @(negedge clk);
        enable    = 1'b0;
        operation = 4'b0010;
        operand_a = 32'h00007F00;
        operand_b = 32'h00007F00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold.result", result, 32'h0000_3F80);
            chk("hold.fpcsr", {28'd0, fpcsr}, 32'h0000_0008);
            chk("hold.valid", {31'd0, valid}, 32'd0);
        end

        // Illegal opcode
        run_op("bad_op",      4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h0000_0000, 4'b1000);

        @(negedge clk);
        enable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
